// File: rtl/poke_disp_pkg.sv
// Shared types and constants for the OLED screen selector / fader.
// Pixels are RGB565 and sit on the pixel_data input of the OLED driver.
package poke_disp_pkg;

  localparam int PIX_W = 16;

  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;

  localparam int MODE_CUT  = 0;
  localparam int MODE_FADE = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    SWAP     = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_e;

endpackage

// File: rtl/rgb565_scale.sv
// Combinational RGB565 brightness scaler: each channel becomes (c*level)>>log2(STEPS).
// level==STEPS is a pass-through and level==0 gives black.
module rgb565_scale
  import poke_disp_pkg::*;
#(
  parameter int STEPS = 8,
  localparam int LVL_W = $clog2(STEPS) + 1
) (
  input  logic [PIX_W-1:0] pixel,
  input  logic [LVL_W-1:0] level,
  output logic [PIX_W-1:0] pixel_out
);

  localparam int SH = $clog2(STEPS);

  logic [5+LVL_W-1:0] r_prod;
  logic [6+LVL_W-1:0] g_prod;
  logic [5+LVL_W-1:0] b_prod;

  // Products are exact; truncation happens in the shift back down.
  always_comb begin
    r_prod = {{LVL_W{1'b0}}, pixel[R_HI:R_LO]} * {5'b0, level};
    g_prod = {{LVL_W{1'b0}}, pixel[G_HI:G_LO]} * {6'b0, level};
    b_prod = {{LVL_W{1'b0}}, pixel[B_HI:B_LO]} * {5'b0, level};
    pixel_out = {5'(r_prod >> SH), 6'(g_prod >> SH), 5'(b_prod >> SH)};
  end

endmodule

// File: rtl/poke_disp_fade.sv
// Selects one of N_SRC RGB565 sources for the OLED stream; screen changes happen
// on frame boundaries, either as a hard cut or as a fade through black.
module poke_disp_fade
  import poke_disp_pkg::*;
#(
  parameter int N_SRC           = 4,
  parameter int SEL_W           = 2,
  parameter int MODE            = 1,
  parameter int STEPS           = 8,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIX_W*N_SRC-1:0] pix_in,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   frame_begin,
  output logic [PIX_W-1:0]       pixel_data,
  output logic [SEL_W-1:0]       cur_sel,
  output logic                   busy
);

  localparam int LVL_W = $clog2(STEPS) + 1;
  localparam int FC_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(STEPS);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FRAMES_PER_STEP - 1);
  localparam logic [SEL_W:0]   N_SRC_W = (SEL_W + 1)'(N_SRC);

  fade_state_e      state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [SEL_W-1:0] tgt_q, tgt_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic             busy_q, busy_d;
  logic [PIX_W-1:0] pixel_q, pixel_d;

  logic             req;
  logic             step;
  logic [FC_W-1:0]  fcnt_inc;
  logic [PIX_W-1:0] src_pix;

  always_comb begin
    src_pix = pix_in[PIX_W*cur_sel_q +: PIX_W];
  end

  rgb565_scale #(.STEPS(STEPS)) u_scale (
    .pixel     (src_pix),
    .level     (level_q),
    .pixel_out (pixel_d)
  );

  // A step fires on every FRAMES_PER_STEP-th frame_begin; the counter is only
  // cleared when leaving IDLE so it runs straight through the SWAP handover.
  always_comb begin
    req      = ({1'b0, sel} < N_SRC_W) && (sel != tgt_q);
    step     = frame_begin && (fcnt_q == FC_LAST);
    fcnt_inc = step ? '0 : fcnt_q + 1'b1;

    state_d   = state_q;
    level_d   = level_q;
    cur_sel_d = cur_sel_q;
    fcnt_d    = fcnt_q;
    busy_d    = busy_q;
    tgt_d     = req ? sel : tgt_q;

    case (state_q)
      IDLE: begin
        fcnt_d = '0;
        if (req) begin
          busy_d  = 1'b1;
          state_d = (MODE == MODE_CUT) ? SWAP : FADE_OUT;
        end
      end
      FADE_OUT: begin
        if (frame_begin) fcnt_d = fcnt_inc;
        if (step) begin
          level_d = level_q - 1'b1;
          if (level_q == LVL_ONE) state_d = SWAP;
        end
      end
      SWAP: begin
        if (MODE == MODE_CUT) begin
          // In cut mode SWAP is the wait for the next frame boundary.
          if (frame_begin) begin
            cur_sel_d = tgt_d;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end
        end else begin
          cur_sel_d = tgt_q;
          state_d   = FADE_IN;
          if (frame_begin) fcnt_d = fcnt_inc;
          if (step) level_d = level_q + 1'b1;
        end
      end
      FADE_IN: begin
        if (frame_begin) fcnt_d = fcnt_inc;
        if (req && (sel != cur_sel_q)) begin
          state_d = FADE_OUT;
        end else if (step) begin
          level_d = level_q + 1'b1;
          if (level_q == LVL_MAX - LVL_ONE) begin
            if (tgt_d == cur_sel_q) begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              state_d = FADE_OUT;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      level_q   <= LVL_MAX;
      tgt_q     <= '0;
      cur_sel_q <= '0;
      fcnt_q    <= '0;
      busy_q    <= 1'b0;
      pixel_q   <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      tgt_q     <= tgt_d;
      cur_sel_q <= cur_sel_d;
      fcnt_q    <= fcnt_d;
      busy_q    <= busy_d;
      pixel_q   <= pixel_d;
    end
  end

  assign pixel_data = pixel_q;
  assign cur_sel    = cur_sel_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_poke_disp_fade.sv
// Scoreboard bench for poke_disp_fade: a fading instance, a hard-cut instance
// and a slow-stepping fading instance, each driven with its own sel/frame_begin.
module tb_poke_disp_fade;

  logic        clk = 1'b0;
  logic        rst_a, rst_o;
  logic [63:0] pix_in;
  logic [1:0]  sel_a, sel_b;
  logic        sel_c;
  logic        fb_a, fb_b, fb_c;
  logic [15:0] pix_a, pix_b, pix_c;
  logic [1:0]  cur_a, cur_b;
  logic        cur_c;
  logic        busy_a, busy_b, busy_c;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [1:0]  dut;
    logic [15:0] pix;
    logic [1:0]  cur;
    logic        busy;
  } exp_t;

  exp_t  sb[$];
  string tag_q[$];

  always #5 clk = ~clk;

  poke_disp_fade #(.N_SRC(3), .SEL_W(2), .MODE(1), .STEPS(8), .FRAMES_PER_STEP(1)) dut_a (
    .clk(clk), .rst(rst_a), .pix_in(pix_in[47:0]), .sel(sel_a), .frame_begin(fb_a),
    .pixel_data(pix_a), .cur_sel(cur_a), .busy(busy_a)
  );

  poke_disp_fade #(.N_SRC(4), .SEL_W(2), .MODE(0), .STEPS(8), .FRAMES_PER_STEP(1)) dut_b (
    .clk(clk), .rst(rst_o), .pix_in(pix_in), .sel(sel_b), .frame_begin(fb_b),
    .pixel_data(pix_b), .cur_sel(cur_b), .busy(busy_b)
  );

  poke_disp_fade #(.N_SRC(2), .SEL_W(1), .MODE(1), .STEPS(4), .FRAMES_PER_STEP(2)) dut_c (
    .clk(clk), .rst(rst_o), .pix_in(pix_in[31:0]), .sel(sel_c), .frame_begin(fb_c),
    .pixel_data(pix_c), .cur_sel(cur_c), .busy(busy_c)
  );

  function automatic logic [15:0] expScale(input logic [15:0] p, input int lvl, input int steps);
    int r, g, b;
    r = int'(p[15:11]) * lvl / steps;
    g = int'(p[10:5]) * lvl / steps;
    b = int'(p[4:0]) * lvl / steps;
    return {r[4:0], g[5:0], b[4:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic pushExpected(input int d, input string tag, input logic [15:0] p,
                              input logic [1:0] c, input logic b);
    exp_t e;
    e.dut  = 2'(d);
    e.pix  = p;
    e.cur  = c;
    e.busy = b;
    sb.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic checkOutputs();
    exp_t        e;
    string       tag;
    logic [15:0] op;
    logic [1:0]  oc;
    logic        ob;
    while (sb.size() != 0) begin
      e   = sb.pop_front();
      tag = tag_q.pop_front();
      case (e.dut)
        2'd0:    begin op = pix_a; oc = cur_a;         ob = busy_a; end
        2'd1:    begin op = pix_b; oc = cur_b;         ob = busy_b; end
        default: begin op = pix_c; oc = {1'b0, cur_c}; ob = busy_c; end
      endcase
      checkOutput({tag, ".pix"},  {16'h0, op},  {16'h0, e.pix});
      checkOutput({tag, ".cur"},  {30'h0, oc},  {30'h0, e.cur});
      checkOutput({tag, ".busy"}, {31'h0, ob},  {31'h0, e.busy});
    end
  endtask

  task automatic applyStimulus(input int d, input int pulses);
    for (int i = 0; i < pulses; i++) begin
      case (d)
        0:       fb_a = 1'b1;
        1:       fb_b = 1'b1;
        default: fb_c = 1'b1;
      endcase
      tick();
      fb_a = 1'b0;
      fb_b = 1'b0;
      fb_c = 1'b0;
      tick();
    end
    checkOutputs();
  endtask

  task automatic idleCycles(input int n);
    repeat (n) tick();
    checkOutputs();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_a = 1'b1; rst_o = 1'b1;
    sel_a = 2'd0; sel_b = 2'd0; sel_c = 1'b0;
    fb_a = 1'b0; fb_b = 1'b0; fb_c = 1'b0;
    pix_in = {16'h001F, 16'hF800, 16'h07E0, 16'hFFFF};

    // Reset behaviour on all three instances
    tick();
    for (int d = 0; d < 3; d++) pushExpected(d, "rst_hold", 16'h0000, 2'd0, 1'b0);
    checkOutputs();
    tick();
    rst_a = 1'b0; rst_o = 1'b0;
    for (int d = 0; d < 3; d++) pushExpected(d, "rst_rel", 16'hFFFF, 2'd0, 1'b0);
    idleCycles(1);

    // Hard cut: request mid-frame, switch on the next frame_begin
    sel_b = 2'd2;
    pushExpected(1, "cut_req", 16'hFFFF, 2'd0, 1'b1);
    idleCycles(1);
    pushExpected(1, "cut_wait", 16'hFFFF, 2'd0, 1'b1);
    idleCycles(2);
    fb_b = 1'b1;
    pushExpected(1, "cut_fb", 16'hFFFF, 2'd2, 1'b0);
    idleCycles(1);
    fb_b = 1'b0;
    pushExpected(1, "cut_pix", 16'hF800, 2'd2, 1'b0);
    idleCycles(1);
    // Request coinciding with frame_begin: that pulse does not apply it
    sel_b = 2'd3; fb_b = 1'b1;
    pushExpected(1, "cut2_req", 16'hF800, 2'd2, 1'b1);
    idleCycles(1);
    fb_b = 1'b0;
    pushExpected(1, "cut2_wait", 16'hF800, 2'd2, 1'b1);
    idleCycles(1);
    fb_b = 1'b1;
    pushExpected(1, "cut2_fb", 16'hF800, 2'd3, 1'b0);
    idleCycles(1);
    fb_b = 1'b0;
    pushExpected(1, "cut2_pix", 16'h001F, 2'd3, 1'b0);
    idleCycles(1);

    // Slow instance: 2 frames per step, 4 steps, 16 pulses in total
    sel_c = 1'b1;
    pushExpected(2, "slow_req", 16'hFFFF, 2'd0, 1'b1);
    idleCycles(1);
    for (int k = 1; k <= 16; k++) begin
      int lvl;
      lvl = (k <= 8) ? 4 - k / 2 : (k - 8) / 2;
      pushExpected(2, $sformatf("slow_%0d", k),
                   expScale((k < 8) ? 16'hFFFF : 16'h07E0, lvl, 4),
                   (k >= 8) ? 2'd1 : 2'd0, (k < 16));
      applyStimulus(2, 1);
    end

    // Full fade 0 -> 1
    sel_a = 2'd1;
    pushExpected(0, "fade_req", 16'hFFFF, 2'd0, 1'b1);
    idleCycles(1);
    for (int k = 1; k <= 8; k++) begin
      pushExpected(0, $sformatf("fade_out_%0d", k), expScale(16'hFFFF, 8 - k, 8),
                   (k == 8) ? 2'd1 : 2'd0, 1'b1);
      if (k == 4) pushExpected(0, "fade_half", 16'h7BEF, 2'd0, 1'b1);
      if (k == 8) pushExpected(0, "fade_black", 16'h0000, 2'd1, 1'b1);
      applyStimulus(0, 1);
    end
    for (int k = 1; k <= 8; k++) begin
      pushExpected(0, $sformatf("fade_in_%0d", k), expScale(16'h07E0, k, 8), 2'd1, (k < 8));
      applyStimulus(0, 1);
    end
    pushExpected(0, "fade_done", 16'h07E0, 2'd1, 1'b0);
    idleCycles(2);

    // Out-of-range select must leave tgt alone
    sel_a = 2'd3;
    pushExpected(0, "oor", 16'h07E0, 2'd1, 1'b0);
    idleCycles(3);
    sel_a = 2'd1;
    pushExpected(0, "oor_tgt", 16'h07E0, 2'd1, 1'b0);
    idleCycles(2);

    // Reset in the middle of a fade-out at level 3
    sel_a = 2'd2;
    idleCycles(1);
    for (int k = 1; k <= 5; k++) begin
      pushExpected(0, $sformatf("pre_rst_%0d", k), expScale(16'h07E0, 8 - k, 8), 2'd1, 1'b1);
      applyStimulus(0, 1);
    end
    rst_a = 1'b1; sel_a = 2'd0;
    pushExpected(0, "mid_rst", 16'h0000, 2'd0, 1'b0);
    idleCycles(1);
    rst_a = 1'b0;
    pushExpected(0, "mid_rst_rel", 16'hFFFF, 2'd0, 1'b0);
    idleCycles(1);
    pushExpected(0, "mid_rst_tgt", 16'hFFFF, 2'd0, 1'b0);
    idleCycles(3);

    // Re-target during fade-in at level 5
    sel_a = 2'd1;
    pushExpected(0, "rt_req", 16'hFFFF, 2'd0, 1'b1);
    idleCycles(1);
    for (int k = 1; k <= 8; k++) begin
      pushExpected(0, $sformatf("rt_out_%0d", k), expScale(16'hFFFF, 8 - k, 8),
                   (k == 8) ? 2'd1 : 2'd0, 1'b1);
      applyStimulus(0, 1);
    end
    for (int k = 1; k <= 5; k++) begin
      pushExpected(0, $sformatf("rt_in_%0d", k), expScale(16'h07E0, k, 8), 2'd1, 1'b1);
      applyStimulus(0, 1);
    end
    sel_a = 2'd0;
    pushExpected(0, "rt_switch", expScale(16'h07E0, 5, 8), 2'd1, 1'b1);
    idleCycles(1);
    for (int k = 1; k <= 5; k++) begin
      pushExpected(0, $sformatf("rt_out2_%0d", k), expScale(16'h07E0, 5 - k, 8),
                   (k == 5) ? 2'd0 : 2'd1, 1'b1);
      applyStimulus(0, 1);
    end
    for (int k = 1; k <= 8; k++) begin
      pushExpected(0, $sformatf("rt_in2_%0d", k), expScale(16'hFFFF, k, 8), 2'd0, (k < 8));
      applyStimulus(0, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
